traffic_input_conditioner: RTL
==============================

# traffic_input_conditioner

Front-end stage feeding `TrafficController`. Synchronizes and debounces the raw road sensor, pedestrian walk button and reprogram button, and latches the walk request until the controller acknowledges it. Turns the reprogram button into a single-cycle pulse, with a captured, stable time-selector/value pair presented alongside it. All outputs drive the same-named controller inputs directly.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles a new input level must persist before it is accepted; legal range 2..15.
- `CNT_W`, default 4: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sensorRaw`  in  1  asynchronous side-road vehicle sensor.
- `walkButton`  in  1  asynchronous pedestrian button.
- `reprogramButton`  in  1  asynchronous reprogram button.
- `selRaw`  in  2  asynchronous time-parameter selector switches.
- `valueRaw`  in  4  asynchronous time-parameter value switches.
- `walkClear`  in  1  synchronous, from controller; clears the latched walk request.
- `sensor`  out  1  debounced sensor level.
- `walkRequest`  out  1  latched walk request, held until cleared.
- `reprogram`  out  1  one-cycle reprogram pulse.
- `extTimeSelector`  out  2  selector captured at the reprogram pulse.
- `extTimeValue`  out  4  value captured at the reprogram pulse.

## Operation
- Synchronizers:
  - Each of the 9 raw input bits passes through a 2-flop synchronizer.
  - `s` denotes the second-stage output.
- Debounce, per channel (sensor, walk, reprogram), with filtered register `f` and counter `c`, evaluated each edge:
  - If `s == f`: `c <= 0`.
  - Else if `c == DEBOUNCE_CYCLES-1`: `f <= s`, `c <= 0`.
  - Else: `c <= c+1`.
  - A level that differs from `f` for fewer than `DEBOUNCE_CYCLES` consecutive synchronized cycles is discarded.
  - Both rising and falling transitions are filtered identically.
- `sensor` is the sensor channel's `f`, driven directly from the register.
- Walk latch:
  - Sets on the edge where the walk channel's `f` goes 0→1.
  - Clears on an edge with `walkClear`=1.
  - Set and clear on the same edge: set wins and `walkRequest` stays 1.
  - Holding the button does not re-set the latch after a clear; a new 0→1 filtered transition is required.
- Reprogram:
  - On the edge where the reprogram channel's `f` goes 0→1:
    - `reprogram <= 1`.
    - `extTimeSelector <= selRaw` (synchronized).
    - `extTimeValue <= valueRaw` (synchronized).
  - On every other edge, `reprogram <= 0`.
  - Captured selector/value hold until the next reprogram pulse.
  - Switch changes between pulses never propagate.
- Reset (any edge with `reset`=1):
  - Clears all synchronizer flops, `f`, `c`, the walk latch, `reprogram`, `extTimeSelector` and `extTimeValue` to 0.
  - Overrides `walkClear` and any in-progress debounce count.
  - After reset deasserts, an input already high is accepted as a fresh 0→1 transition.

## Timing
- Reset values of all outputs: 0.
- Latency, with edge 1 defined as the first edge sampling a new raw level:
  - Edge 1: synchronizer stage 1 captures.
  - Edge 2: `s` updates.
  - Edges 3..`DEBOUNCE_CYCLES+2`: counting.
  - `f` and the dependent outputs update on edge `DEBOUNCE_CYCLES+2`.
  - Default parameters: 6 edges.
- `walkRequest` rise, `reprogram` pulse and the selector/value capture all occur on that same edge.
- `reprogram` is high for exactly one clock period per accepted button press.
- `walkClear` takes effect on the edge it is sampled; `walkRequest` is low the following cycle unless a set coincides.
- Counter wrap is impossible: `c` never exceeds `DEBOUNCE_CYCLES-1`.
- The block requires no handshake besides `walkClear`.

## Test plan
- Reset, then `sensorRaw`=1 held: `sensor` rises on edge 6 after the first sampling edge. Drop `sensorRaw`: `sensor` falls 6 edges later.
- `walkButton` glitch high for 3 cycles (`DEBOUNCE_CYCLES`=4): `walkRequest` stays 0. Pulse for 10 cycles: `walkRequest` rises on edge 6 and remains 1 after button release until `walkClear`=1 for one cycle, then reads 0 the next cycle.
- `walkClear`=1 asserted on the same edge the filtered walk rises: `walkRequest`=1 afterwards.
- `selRaw`=0, `valueRaw`=4'd4, then press `reprogramButton` for 20 cycles: exactly one `reprogram`=1 cycle, with `extTimeSelector`=0 and `extTimeValue`=4 valid in that cycle. Then change `valueRaw` to 9 without pressing: `extTimeValue` stays 4.
- Assert `reset` mid-debounce (button held 3 cycles) and with `walkRequest`=1: all outputs 0 next cycle. Button still held after reset release: `walkRequest` sets 6 edges later.
- Sensor chatter alternating every 2 cycles for 40 cycles: `sensor` never changes.

Source files
------------

// File: rtl/traffic_input_conditioner.sv
// Front end for TrafficController: 2-flop sync and debounce of raw buttons/sensor, walk latch, reprogram pulse.
// Latency: DEBOUNCE_CYCLES+2 edges from a raw level change to sensor/walkRequest/reprogram.
// Backpressure: none; walkClear from the controller is the only feedback and clears the walk latch.
module traffic_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensorRaw,
  input  logic       walkButton,
  input  logic       reprogramButton,
  input  logic [1:0] selRaw,
  input  logic [3:0] valueRaw,
  input  logic       walkClear,
  output logic       sensor,
  output logic       walkRequest,
  output logic       reprogram,
  output logic [1:0] extTimeSelector,
  output logic [3:0] extTimeValue
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit layout: {value[3:0], sel[1:0], reprogram, walk, sensor}
  logic [8:0]       sync1;
  logic [8:0]       sync2;
  logic [2:0]       filt;
  logic [2:0]       filt_nxt;
  logic [2:0]       rise;
  logic [CNT_W-1:0] cnt     [3];
  logic [CNT_W-1:0] cnt_nxt [3];

  always_comb begin
    filt_nxt = filt;
    for (int i = 0; i < 3; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != filt[i]) begin
        if (cnt[i] == CNT_MAX) filt_nxt[i] = sync2[i];
        else                   cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  assign rise   = filt_nxt & ~filt;
  assign sensor = filt[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1           <= '0;
      sync2           <= '0;
      filt            <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      walkRequest     <= 1'b0;
      reprogram       <= 1'b0;
      extTimeSelector <= '0;
      extTimeValue    <= '0;
    end else begin
      sync1 <= {valueRaw, selRaw, reprogramButton, walkButton, sensorRaw};
      sync2 <= sync1;
      filt  <= filt_nxt;
      for (int i = 0; i < 3; i++) cnt[i] <= cnt_nxt[i];
      // A new filtered press beats a coincident clear
      if (rise[1])        walkRequest <= 1'b1;
      else if (walkClear) walkRequest <= 1'b0;
      reprogram <= rise[2];
      if (rise[2]) begin
        extTimeSelector <= sync2[4:3];
        extTimeValue    <= sync2[8:5];
      end
    end
  end

endmodule
